// File: rtl/forward_hazard_unit_pkg.sv
// Shared types and sizing for the bypass-select / hazard unit.
package forward_hazard_unit_pkg;

  localparam int NSRC   = 2;   // source operands checked per cycle
  localparam int NSTAGE = 3;   // producer stages, 0 = youngest
  localparam int NREG   = 32;  // architectural registers, r0 hard-wired zero
  localparam int LAT_W  = 3;   // pending-latency counter width
  localparam int REG_W  = 5;
  localparam int FSEL_W = $clog2(NSTAGE + 1);

  typedef logic [REG_W-1:0]  regbits_t;
  typedef logic [FSEL_W-1:0] fwd_sel_t;
  typedef logic [LAT_W-1:0]  lat_t;

  // Select value meaning "take the operand from the register file".
  localparam fwd_sel_t FWD_REGFILE = '0;

endpackage

// File: rtl/forward_hazard_unit_if.sv
// Pipeline-side bundle for the hazard unit: operand/producer info in,
// bypass selects, stall and stall statistics out.
interface forward_hazard_unit_if;
  import forward_hazard_unit_pkg::*;

  regbits_t [NSRC-1:0]   src_rs;
  logic     [NSRC-1:0]   src_used;
  regbits_t [NSTAGE-1:0] stg_rd;
  logic     [NSTAGE-1:0] stg_regwrite;
  logic     [NSTAGE-1:0] stg_ready;
  logic                  issue_valid;
  regbits_t              issue_rd;
  lat_t                  issue_lat;
  logic                  flush;
  fwd_sel_t [NSRC-1:0]   fwd_sel;
  logic                  stall;
  logic     [31:0]       stall_cnt;

  // Pipeline control side
  modport master (
    output src_rs, src_used, stg_rd, stg_regwrite, stg_ready,
           issue_valid, issue_rd, issue_lat, flush,
    input  fwd_sel, stall, stall_cnt
  );

  // Hazard unit side
  modport slave (
    input  src_rs, src_used, stg_rd, stg_regwrite, stg_ready,
           issue_valid, issue_rd, issue_lat, flush,
    output fwd_sel, stall, stall_cnt
  );

endinterface

// File: rtl/forward_hazard_unit_scoreboard.sv
// Per-register pending-latency scoreboard for long-latency producers.
// Each entry counts down to zero; a nonzero entry means the result is
// not yet available. Entry 0 is never written and always reads idle.
module hazard_scoreboard
  import forward_hazard_unit_pkg::*;
#(
  parameter int NRD = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_we,
  input  regbits_t            issue_rd,
  input  lat_t                issue_lat,
  input  regbits_t [NRD-1:0]  rd_addr,
  output logic     [NRD-1:0]  rd_busy
);

  lat_t sb [NREG];

  // Countdown every entry; a new issue overrides the decrement of its entry.
  // NOTE: this array gets an async reset on purpose -- reset must clear every
  // pending result at once, so it cannot be mapped onto a reset-less RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) sb[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (issue_we && issue_rd == regbits_t'(r))
          sb[r] <= issue_lat;
        else if (sb[r] != '0)
          sb[r] <= sb[r] - lat_t'(1);
      end
    end
  end

  // Read ports: busy while the entry's counter is still running.
  always_comb begin
    for (int j = 0; j < NRD; j++) rd_busy[j] = (sb[rd_addr[j]] != '0);
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Bypass-select and hazard unit: chooses the youngest producing stage for
// each source operand and raises stall for load-use, scoreboard and WAW hazards.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
(
  input  logic                  CLK,
  input  logic                  nRST,
  forward_hazard_unit_if.slave  bus
);

  // One read port per source plus one for the issuing destination (WAW).
  localparam int NRD = NSRC + 1;

  regbits_t [NRD-1:0]  rd_addr;
  logic     [NRD-1:0]  rd_busy;
  fwd_sel_t [NSRC-1:0] fwd_sel;
  logic     [NSRC-1:0] src_stall;
  logic                waw_stall;
  logic                stall;
  logic                sb_we;
  logic     [31:0]     stall_cnt;

  // Scoreboard lookup addresses.
  always_comb begin
    for (int i = 0; i < NSRC; i++) rd_addr[i] = bus.src_rs[i];
    rd_addr[NSRC] = bus.issue_rd;
  end

  // Per-source bypass select (lowest matching stage wins) and source hazards.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic hit;
    fwd_sel   = '0;
    src_stall = '0;
    hit       = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      fwd_sel[i] = FWD_REGFILE;
      hit        = 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        if (!hit && bus.src_used[i] && bus.stg_regwrite[k] &&
            bus.src_rs[i] != '0 && bus.stg_rd[k] == bus.src_rs[i]) begin
          hit          = 1'b1;
          fwd_sel[i]   = fwd_sel_t'(k + 1);
          src_stall[i] = !bus.stg_ready[k];
        end
      end
      if (rd_busy[i]) src_stall[i] = 1'b1;
    end
  end

  // A new long-latency write must not overtake one still in flight.
  assign waw_stall = bus.issue_valid && (bus.issue_lat != '0) && rd_busy[NSRC];
  assign stall     = (|src_stall) || waw_stall;

  // Only an issue that actually leaves ID this cycle claims a scoreboard entry.
  assign sb_we = bus.issue_valid && !stall && !bus.flush &&
                 (bus.issue_rd != '0) && (bus.issue_lat != '0);

  hazard_scoreboard #(.NRD(NRD)) u_sb (
    .clk       (CLK),
    .rst_n     (nRST),
    .issue_we  (sb_we),
    .issue_rd  (bus.issue_rd),
    .issue_lat (bus.issue_lat),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy)
  );

  // Saturating stall-cycle statistic.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.fwd_sel   = fwd_sel;
  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard-style bench for forward_hazard_unit: the driver applies one
// vector per cycle and queues the reference model's expectation; a monitor
// on the falling edge pops and compares.
module tb_forward_hazard_unit;
  import forward_hazard_unit_pkg::*;

  typedef struct {
    regbits_t [NSRC-1:0]   rs;
    logic     [NSRC-1:0]   used;
    regbits_t [NSTAGE-1:0] rd;
    logic     [NSTAGE-1:0] rw;
    logic     [NSTAGE-1:0] rdy;
    logic                  iv;
    regbits_t              ird;
    lat_t                  ilat;
    logic                  fl;
    logic                  rst_n;
  } stim_t;

  typedef struct {
    int                  id;
    fwd_sel_t [NSRC-1:0] fsel;
    logic                stall;
    logic [31:0]         cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  forward_hazard_unit_if bus ();

  forward_hazard_unit dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: remaining cycles per register, stall total.
  int     sb_m [NREG];
  longint cnt_m;
  exp_t   exp_q [$];
  int     n_vec;
  int     n_cmp;
  int     n_err;

  task automatic check(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, id, act, req);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rs = '0; s.used = '0; s.rd = '0; s.rw = '0; s.rdy = '1;
    s.iv = 1'b0; s.ird = '0; s.ilat = '0; s.fl = 1'b0; s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = idle();
    for (int i = 0; i < NSRC; i++) begin
      s.rs[i]   = regbits_t'($urandom_range(0, 7));
      s.used[i] = ($urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < NSTAGE; k++) begin
      s.rd[k]  = regbits_t'($urandom_range(0, 7));
      s.rw[k]  = ($urandom_range(0, 3) != 0);
      s.rdy[k] = ($urandom_range(0, 3) != 0);
    end
    s.iv    = ($urandom_range(0, 1) != 0);
    s.ird   = regbits_t'($urandom_range(0, 7));
    s.ilat  = ($urandom_range(0, 1) != 0) ? lat_t'($urandom_range(1, 7)) : '0;
    s.fl    = ($urandom_range(0, 7) == 0);
    s.rst_n = ($urandom_range(0, 99) != 0);
    return s;
  endfunction

  // Drive one vector after the rising edge, queue the expectation, advance model.
  task automatic apply(input stim_t s);
    exp_t e;
    bit   st;
    @(posedge clk);
    #1;
    rst_n            = s.rst_n;
    bus.src_rs       = s.rs;
    bus.src_used     = s.used;
    bus.stg_rd       = s.rd;
    bus.stg_regwrite = s.rw;
    bus.stg_ready    = s.rdy;
    bus.issue_valid  = s.iv;
    bus.issue_rd     = s.ird;
    bus.issue_lat    = s.ilat;
    bus.flush        = s.fl;
    if (!s.rst_n) begin
      foreach (sb_m[r]) sb_m[r] = 0;
      cnt_m = 0;
    end
    st = 0;
    e.id = n_vec;
    for (int i = 0; i < NSRC; i++) begin
      int sel;
      sel = 0;
      if (s.used[i] && s.rs[i] != 0)
        for (int k = NSTAGE - 1; k >= 0; k--)
          if (s.rw[k] && s.rd[k] == s.rs[i]) sel = k + 1;
      e.fsel[i] = fwd_sel_t'(sel);
      if (sel != 0 && !s.rdy[sel-1]) st = 1;
      if (sb_m[s.rs[i]] > 0) st = 1;
    end
    if (s.iv && s.ilat != 0 && sb_m[s.ird] > 0) st = 1;
    e.stall = st;
    e.cnt   = cnt_m[31:0];
    exp_q.push_back(e);
    n_vec++;
    if (s.rst_n) begin
      foreach (sb_m[r]) if (sb_m[r] > 0) sb_m[r]--;
      if (s.iv && !st && !s.fl && s.ird != 0 && s.ilat != 0) sb_m[s.ird] = int'(s.ilat);
      if (st && cnt_m < 64'hFFFF_FFFF) cnt_m++;
    end
  endtask

  // Monitor: compare the queued expectation against the settled outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        for (int i = 0; i < NSRC; i++)
          check($sformatf("fwd_sel[%0d]", i), e.id, 32'(bus.fwd_sel[i]), 32'(e.fsel[i]));
        check("stall", e.id, 32'(bus.stall), 32'(e.stall));
        check("stall_cnt", e.id, bus.stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    n_vec = 0; n_cmp = 0; n_err = 0; cnt_m = 0;
    foreach (sb_m[r]) sb_m[r] = 0;
    rst_n = 1'b0;
    s = idle();
    bus.src_rs = s.rs; bus.src_used = s.used; bus.stg_rd = s.rd;
    bus.stg_regwrite = s.rw; bus.stg_ready = s.rdy; bus.issue_valid = 1'b0;
    bus.issue_rd = '0; bus.issue_lat = '0; bus.flush = 1'b0;

    // Reset state
    s = idle(); s.rst_n = 1'b0;
    apply(s); apply(s);

    // Youngest matching stage wins
    s = idle(); s.rs[0] = 5; s.used[0] = 1; s.rd = {5'd9, 5'd5, 5'd5}; s.rw = '1;
    apply(s);

    // Load-use: not ready in stage 0, then ready in stage 1
    s = idle(); s.rs[1] = 7; s.used[1] = 1; s.rd[0] = 7; s.rw[0] = 1; s.rdy[0] = 0;
    apply(s);
    s = idle(); s.rs[1] = 7; s.used[1] = 1; s.rd[1] = 7; s.rw[1] = 1;
    apply(s);

    // Long-latency producer: stall three cycles, clear on the fourth
    s = idle(); s.iv = 1; s.ird = 4; s.ilat = 3;
    apply(s);
    for (int c = 0; c < 5; c++) begin
      s = idle(); s.rs[0] = 4; s.used[0] = 1;
      apply(s);
    end

    // Register zero never forwards and never enters the scoreboard
    s = idle(); s.used[0] = 1; s.rw[0] = 1;
    apply(s);
    s = idle(); s.iv = 1; s.ird = 0; s.ilat = 5;
    apply(s);
    s = idle(); s.used = '1;
    apply(s);

    // Flush suppresses only its own issue; older counters keep running
    s = idle(); s.iv = 1; s.ird = 9; s.ilat = 4;
    apply(s);
    s = idle(); s.iv = 1; s.ird = 6; s.ilat = 2; s.fl = 1;
    apply(s);
    for (int c = 0; c < 4; c++) begin
      s = idle(); s.rs = {5'd9, 5'd6};
      apply(s);
    end

    // WAW then reset mid-count
    s = idle(); s.iv = 1; s.ird = 3; s.ilat = 2;
    apply(s);
    s = idle(); s.iv = 1; s.ird = 3; s.ilat = 4;
    apply(s);
    s = idle(); s.iv = 1; s.ird = 3; s.ilat = 4; s.rst_n = 0;
    apply(s);
    s = idle(); s.rs[0] = 3;
    apply(s);

    // Randomised traffic
    for (int n = 0; n < 600; n++) apply(rnd());

    // Drain the expectation queue with a bounded wait
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    if (n_cmp < 12) begin
      n_err++;
      $display("FAIL compare_count: got %0d expected at least 12", n_cmp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
